// File: rtl/dma_pkg.sv
// Shared types, encodings and chunk-size helper for the DMA master engine.
// AXI width macros get defaults here unless the system defines them first.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP,
    DONE
  } dma_state_e;

  localparam int DMA_MAX_BEATS = 16;
  localparam int DMA_4K_WORDS  = 1024;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Beats for the next chunk: bounded by what is left, the burst limit, and
  // the words remaining before the next 4 KB page on either side.
  function automatic logic [31:0] chunk_beats(input logic [31:0] rem,
                                              input logic [9:0]  src_word,
                                              input logic [9:0]  dst_word,
                                              input logic [31:0] max_beats);
    logic [31:0] beats;
    logic [31:0] src_room;
    logic [31:0] dst_room;
    src_room = 32'(DMA_4K_WORDS) - {22'd0, src_word};
    dst_room = 32'(DMA_4K_WORDS) - {22'd0, dst_word};
    beats = rem;
    if (max_beats < beats) beats = max_beats;
    if (src_room < beats)  beats = src_room;
    if (dst_room < beats)  beats = dst_room;
    return beats;
  endfunction

endpackage

// File: rtl/dma_axi_if.sv
// AXI4 master-side bus bundle used by the DMA engine.
interface dma_axi_if;

  logic [`AXI_ID_BITS-1:0]   M_ARID;
  logic [`AXI_ADDR_BITS-1:0] M_ARAddr;
  logic [`AXI_LEN_BITS-1:0]  M_ARLen;
  logic [`AXI_SIZE_BITS-1:0] M_ARSize;
  logic [1:0]                M_ARBurst;
  logic                      M_ARValid;
  logic                      M_ARReady;

  logic [`AXI_ID_BITS-1:0]   M_RID;
  logic [`AXI_DATA_BITS-1:0] M_RData;
  logic [1:0]                M_RResp;
  logic                      M_RLast;
  logic                      M_RValid;
  logic                      M_RReady;

  logic [`AXI_ID_BITS-1:0]   M_AWID;
  logic [`AXI_ADDR_BITS-1:0] M_AWAddr;
  logic [`AXI_LEN_BITS-1:0]  M_AWLen;
  logic [`AXI_SIZE_BITS-1:0] M_AWSize;
  logic [1:0]                M_AWBurst;
  logic                      M_AWValid;
  logic                      M_AWReady;

  logic [`AXI_DATA_BITS-1:0] M_WData;
  logic [`AXI_STRB_BITS-1:0] M_WStrb;
  logic                      M_WLast;
  logic                      M_WValid;
  logic                      M_WReady;

  logic [`AXI_ID_BITS-1:0]   M_BID;
  logic [1:0]                M_BResp;
  logic                      M_BValid;
  logic                      M_BReady;

  modport master (
    output M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    input  M_ARReady,
    input  M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    output M_RReady,
    output M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid,
    input  M_AWReady,
    output M_WData, M_WStrb, M_WLast, M_WValid,
    input  M_WReady,
    input  M_BID, M_BResp, M_BValid,
    output M_BReady
  );

  modport slave (
    input  M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    output M_ARReady,
    output M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    input  M_RReady,
    input  M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid,
    output M_AWReady,
    input  M_WData, M_WStrb, M_WLast, M_WValid,
    output M_WReady,
    output M_BID, M_BResp, M_BValid,
    input  M_BReady
  );

endinterface

// File: rtl/dma_buf.sv
// Chunk staging buffer: one write port, asynchronous read port.
module dma_buf #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             ACLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the data array has no reset; each word is filled by a read beat
  // before the matching write beat can look at it.
  always_ff @(posedge ACLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_master.sv
// DMA AXI master: copies DMALEN words from DMASRC to DMADST, one read burst
// into the staging buffer then one write burst out of it per chunk.
module dma_master
  import dma_pkg::*;
#(
  parameter int MAX_BEATS = DMA_MAX_BEATS
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      DMAEN,
  input  logic [`AXI_DATA_BITS-1:0] DMASRC,
  input  logic [`AXI_DATA_BITS-1:0] DMADST,
  input  logic [`AXI_DATA_BITS-1:0] DMALEN,
  output logic                      DMA_done,
  output logic                      DMA_err,
  dma_axi_if.master                 axi
);

  localparam int IDX_BITS = $clog2(MAX_BEATS);
  localparam int LB       = `AXI_LEN_BITS;
  localparam int AB       = `AXI_ADDR_BITS;

  dma_state_e                state, state_nx;
  logic [`AXI_DATA_BITS-1:0] src, dst, rem;
  logic [LB-1:0]             len_q;
  logic [IDX_BITS-1:0]       rcnt, wcnt;
  logic                      ar_valid, aw_valid, err;
  logic [31:0]               beats, rem_left;
  logic                      ar_hs, r_hs, aw_hs, w_hs, b_hs, w_last;
  logic [31:0]               buf_rdata;
  logic                      unused_ids;

  assign ar_hs    = ar_valid & axi.M_ARReady;
  assign r_hs     = (state == RDATA) & axi.M_RValid;
  assign aw_hs    = aw_valid & axi.M_AWReady;
  assign w_hs     = (state == WDATA) & axi.M_WReady;
  assign b_hs     = (state == WRESP) & axi.M_BValid;
  assign w_last   = (state == WDATA) && (LB'(wcnt) == len_q);
  assign beats    = 32'(len_q) + 32'd1;
  assign rem_left = rem - beats;

  // NOTE: defaults first so every path assigns state_nx and no latch forms.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (DMAEN) state_nx = (DMALEN == '0) ? DONE : RADDR;
      RADDR:   if (ar_hs) state_nx = RDATA;
      RDATA:   if (r_hs && axi.M_RLast) state_nx = WADDR;
      WADDR:   if (aw_hs) state_nx = WDATA;
      WDATA:   if (w_hs && w_last) state_nx = WRESP;
      WRESP:   if (b_hs) state_nx = (rem_left == '0) ? DONE : RADDR;
      DONE:    if (!DMAEN) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      rem      <= '0;
      len_q    <= '0;
      rcnt     <= '0;
      wcnt     <= '0;
      ar_valid <= 1'b0;
      aw_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && DMAEN) begin
        src <= DMASRC & ~32'd3;
        dst <= DMADST & ~32'd3;
        rem <= DMALEN;
        err <= 1'b0;
      end
      // Chunk size is fixed in the first RADDR cycle, before ARValid rises.
      if (state == RADDR && !ar_valid)
        len_q <= LB'(chunk_beats(rem, src[11:2], dst[11:2], 32'(MAX_BEATS)) - 32'd1);
      ar_valid <= (state == RADDR) && !ar_hs;
      aw_valid <= (state == WADDR) && !aw_hs;
      if (r_hs) rcnt <= axi.M_RLast ? '0 : rcnt + IDX_BITS'(1);
      if (w_hs) wcnt <= w_last ? '0 : wcnt + IDX_BITS'(1);
      if ((r_hs && axi.M_RResp != AXI_RESP_OKAY) || (b_hs && axi.M_BResp != AXI_RESP_OKAY))
        err <= 1'b1;
      if (b_hs) begin
        src <= src + (beats << 2);
        dst <= dst + (beats << 2);
        rem <= rem_left;
      end
    end
  end

  dma_buf #(.DEPTH(MAX_BEATS), .WIDTH(32)) u_buf (
    .ACLK  (ACLK),
    .we    (r_hs),
    .waddr (rcnt),
    .wdata (axi.M_RData),
    .raddr (wcnt),
    .rdata (buf_rdata)
  );

  // Fixed fields are gated by Valid so every output reads 0 out of reset.
  assign axi.M_ARID    = '0;
  assign axi.M_ARAddr  = AB'(src);
  assign axi.M_ARLen   = len_q;
  assign axi.M_ARSize  = ar_valid ? AXI_SIZE_4B : '0;
  assign axi.M_ARBurst = ar_valid ? AXI_BURST_INCR : '0;
  assign axi.M_ARValid = ar_valid;
  assign axi.M_RReady  = (state == RDATA);

  assign axi.M_AWID    = '0;
  assign axi.M_AWAddr  = AB'(dst);
  assign axi.M_AWLen   = len_q;
  assign axi.M_AWSize  = aw_valid ? AXI_SIZE_4B : '0;
  assign axi.M_AWBurst = aw_valid ? AXI_BURST_INCR : '0;
  assign axi.M_AWValid = aw_valid;

  assign axi.M_WValid  = (state == WDATA);
  assign axi.M_WData   = axi.M_WValid ? buf_rdata : '0;
  assign axi.M_WStrb   = axi.M_WValid ? '1 : '0;
  assign axi.M_WLast   = w_last;
  assign axi.M_BReady  = (state == WRESP);

  assign DMA_done = (state == DONE);
  assign DMA_err  = err;

  assign unused_ids = ^{axi.M_RID, axi.M_BID};

endmodule

// File: tb/tb_dma_master.sv
// Self-checking bench for dma_master: a randomly stalling AXI memory slave and
// a scoreboard of expected AR/AW requests and write data.
module tb_dma_master;
  import dma_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
  } burst_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        DMAEN;
  logic [31:0] DMASRC, DMADST, DMALEN;
  logic        DMA_done, DMA_err;

  dma_axi_if axi ();

  dma_master dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .DMAEN    (DMAEN),
    .DMASRC   (DMASRC),
    .DMADST   (DMADST),
    .DMALEN   (DMALEN),
    .DMA_done (DMA_done),
    .DMA_err  (DMA_err),
    .axi      (axi)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard and slave memory
  burst_t      exp_ar[$], exp_aw[$], rd_q[$], wr_q[$];
  logic [31:0] exp_w[$];
  logic [31:0] mem [logic [31:0]];

  int stall_pct = 0;
  int berr_idx  = -1;
  int rerr_beat = -1;
  int b_idx = 0, r_idx = 0;
  int rbeat = 0, wbeat = 0, b_pend = 0;
  bit r_hold = 0, b_hold = 0, ar_pend = 0, aw_pend = 0, w_pend = 0;
  logic [31:0] ar_addr_q, aw_addr_q, wdata_q;
  logic [3:0]  ar_len_q, aw_len_q;
  logic        wlast_q;

  function automatic bit rnd_ok();
    return ($urandom_range(99) >= stall_pct);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (32'hDEAD_0000 ^ a);
  endfunction

  task automatic slave_idle();
    axi.M_ARReady = 1'b0; axi.M_AWReady = 1'b0; axi.M_WReady = 1'b0;
    axi.M_RID = '0; axi.M_RData = '0; axi.M_RResp = '0; axi.M_RLast = 1'b0; axi.M_RValid = 1'b0;
    axi.M_BID = '0; axi.M_BResp = '0; axi.M_BValid = 1'b0;
    rd_q.delete(); wr_q.delete();
    rbeat = 0; wbeat = 0; b_pend = 0;
    r_hold = 0; b_hold = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
  endtask

  // Slave: at each falling edge, decide inputs for the next rising edge and
  // account for the handshakes that edge will complete.
  initial begin : slave
    burst_t e;
    slave_idle();
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        slave_idle();
        continue;
      end

      // Read address
      if (ar_pend) begin
        check("ar_valid_held", 32'(axi.M_ARValid), 1);
        check("ar_addr_stable", axi.M_ARAddr, ar_addr_q);
        check("ar_len_stable", 32'(axi.M_ARLen), 32'(ar_len_q));
      end
      axi.M_ARReady = rnd_ok();
      if (axi.M_ARValid && axi.M_ARReady) begin
        check("ar_expected", 32'(exp_ar.size() != 0), 1);
        if (exp_ar.size() != 0) begin
          e = exp_ar.pop_front();
          check("ar_addr", axi.M_ARAddr, e.addr);
          check("ar_len", 32'(axi.M_ARLen), 32'(e.len));
        end
        check("ar_size_burst_id", {axi.M_ARID, axi.M_ARSize, axi.M_ARBurst},
              {4'd0, AXI_SIZE_4B, AXI_BURST_INCR});
        rd_q.push_back('{axi.M_ARAddr, axi.M_ARLen});
      end
      ar_pend = axi.M_ARValid && !axi.M_ARReady;
      ar_addr_q = axi.M_ARAddr;
      ar_len_q  = axi.M_ARLen;

      // Read data
      if (rd_q.size() != 0) begin
        if (!r_hold) axi.M_RValid = rnd_ok();
        axi.M_RData = mem_rd(rd_q[0].addr + 32'(rbeat * 4));
        axi.M_RLast = (rbeat == int'(rd_q[0].len));
        axi.M_RResp = (r_idx == rerr_beat) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
        if (axi.M_RValid && axi.M_RReady) begin
          r_hold = 0;
          r_idx++;
          if (axi.M_RLast) begin
            void'(rd_q.pop_front());
            rbeat = 0;
          end else rbeat++;
        end else r_hold = axi.M_RValid;
      end else begin
        axi.M_RValid = 1'b0;
        axi.M_RLast  = 1'b0;
        r_hold = 0;
      end

      // Write address
      if (aw_pend) begin
        check("aw_valid_held", 32'(axi.M_AWValid), 1);
        check("aw_addr_stable", axi.M_AWAddr, aw_addr_q);
        check("aw_len_stable", 32'(axi.M_AWLen), 32'(aw_len_q));
      end
      axi.M_AWReady = rnd_ok();
      if (axi.M_AWValid && axi.M_AWReady) begin
        check("aw_expected", 32'(exp_aw.size() != 0), 1);
        if (exp_aw.size() != 0) begin
          e = exp_aw.pop_front();
          check("aw_addr", axi.M_AWAddr, e.addr);
          check("aw_len", 32'(axi.M_AWLen), 32'(e.len));
        end
        check("aw_size_burst_id", {axi.M_AWID, axi.M_AWSize, axi.M_AWBurst},
              {4'd0, AXI_SIZE_4B, AXI_BURST_INCR});
        wr_q.push_back('{axi.M_AWAddr, axi.M_AWLen});
      end
      aw_pend = axi.M_AWValid && !axi.M_AWReady;
      aw_addr_q = axi.M_AWAddr;
      aw_len_q  = axi.M_AWLen;

      // Write data
      if (w_pend) begin
        check("w_valid_held", 32'(axi.M_WValid), 1);
        check("w_data_stable", axi.M_WData, wdata_q);
        check("w_last_stable", 32'(axi.M_WLast), 32'(wlast_q));
      end
      axi.M_WReady = rnd_ok();
      if (axi.M_WValid && axi.M_WReady) begin
        check("w_has_aw", 32'(wr_q.size() != 0), 1);
        check("w_expected", 32'(exp_w.size() != 0), 1);
        if (exp_w.size() != 0) check("w_data", axi.M_WData, exp_w.pop_front());
        check("w_strb", 32'(axi.M_WStrb), 32'hF);
        if (wr_q.size() != 0) begin
          mem[wr_q[0].addr + 32'(wbeat * 4)] = axi.M_WData;
          check("w_last", 32'(axi.M_WLast), 32'(wbeat == int'(wr_q[0].len)));
          if (wbeat == int'(wr_q[0].len)) begin
            void'(wr_q.pop_front());
            wbeat = 0;
            b_pend++;
          end else wbeat++;
        end
      end
      w_pend = axi.M_WValid && !axi.M_WReady;
      wdata_q = axi.M_WData;
      wlast_q = axi.M_WLast;

      // Write response
      if (b_pend > 0) begin
        if (!b_hold) axi.M_BValid = rnd_ok();
        axi.M_BResp = (b_idx == berr_idx) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (axi.M_BValid && axi.M_BReady) begin
          b_pend--;
          b_idx++;
          b_hold = 0;
        end else b_hold = axi.M_BValid;
      end else begin
        axi.M_BValid = 1'b0;
        b_hold = 0;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, ":ar_ctl"}, 32'({axi.M_ARID, axi.M_ARLen, axi.M_ARSize, axi.M_ARBurst, axi.M_ARValid}), 0);
    check({tag, ":ar_addr"}, axi.M_ARAddr, 0);
    check({tag, ":aw_ctl"}, 32'({axi.M_AWID, axi.M_AWLen, axi.M_AWSize, axi.M_AWBurst, axi.M_AWValid}), 0);
    check({tag, ":aw_addr"}, axi.M_AWAddr, 0);
    check({tag, ":w_data"}, axi.M_WData, 0);
    check({tag, ":misc"}, 32'({axi.M_WStrb, axi.M_WLast, axi.M_WValid, axi.M_RReady,
                               axi.M_BReady, DMA_done, DMA_err}), 0);
  endtask

  // Preload source words and push every AR, AW and W beat the transfer should produce.
  task automatic plan_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                           output logic [31:0] words[$]);
    logic [31:0] s, d, r, b, room;
    s = src & ~32'd3;
    d = dst & ~32'd3;
    r = len;
    words.delete();
    for (int i = 0; i < int'(len); i++) begin
      mem[s + 32'(i * 4)] = $urandom;
      words.push_back(mem[s + 32'(i * 4)]);
    end
    while (r != 0) begin
      b = (r > 16) ? 32'd16 : r;
      room = (32'h1000 - {20'd0, s[11:0]}) >> 2;
      if (room < b) b = room;
      room = (32'h1000 - {20'd0, d[11:0]}) >> 2;
      if (room < b) b = room;
      exp_ar.push_back('{s, 4'(b - 1)});
      exp_aw.push_back('{d, 4'(b - 1)});
      for (int k = 0; k < int'(b); k++) exp_w.push_back(mem[s + 32'(k * 4)]);
      s += b * 4;
      d += b * 4;
      r -= b;
    end
    b_idx = 0;
    r_idx = 0;
  endtask

  task automatic run_xfer(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] len, input int stall, input int berr,
                          input int rerr, input int exp_lat);
    logic [31:0] words[$];
    int cycles;
    stall_pct = stall;
    berr_idx  = berr;
    rerr_beat = rerr;
    plan_xfer(src, dst, len, words);
    @(negedge ACLK);
    DMAEN = 1'b1; DMASRC = src; DMADST = dst; DMALEN = len;
    cycles = 0;
    do begin
      @(negedge ACLK);
      cycles++;
      if (cycles == 1) check({name, ":err_cleared"}, 32'(DMA_err), 0);
    end while (!DMA_done && cycles < 4000);
    check({name, ":done"}, 32'(DMA_done), 1);
    if (exp_lat > 0) check({name, ":latency"}, cycles, exp_lat);
    check({name, ":ar_left"}, exp_ar.size(), 0);
    check({name, ":aw_left"}, exp_aw.size(), 0);
    check({name, ":w_left"}, exp_w.size(), 0);
    for (int i = 0; i < int'(len); i++)
      check({name, ":dst_word"}, mem_rd((dst & ~32'd3) + 32'(i * 4)), words[i]);
    check({name, ":err"}, 32'(DMA_err), 32'(berr >= 0 || rerr >= 0));
    repeat (3) @(negedge ACLK);
    check({name, ":done_held"}, 32'(DMA_done), 1);
    check({name, ":no_restart"}, 32'(axi.M_ARValid | axi.M_AWValid), 0);
    DMAEN = 1'b0;
    @(negedge ACLK);
    check({name, ":done_dropped"}, 32'(DMA_done), 0);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete();
  endtask

  task automatic reset_in_wdata();
    logic [31:0] words[$];
    int cycles;
    stall_pct = 0; berr_idx = -1; rerr_beat = -1;
    plan_xfer(32'hF000, 32'hF800, 32'd8, words);
    @(negedge ACLK);
    DMAEN = 1'b1; DMASRC = 32'hF000; DMADST = 32'hF800; DMALEN = 32'd8;
    cycles = 0;
    do begin
      @(negedge ACLK);
      cycles++;
    end while (!axi.M_WValid && cycles < 200);
    check("rst_mid:reached_wdata", 32'(axi.M_WValid), 1);
    ARESETn = 1'b0;
    @(negedge ACLK);
    check_outputs_zero("rst_mid");
    DMAEN = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    repeat (3) @(negedge ACLK);
    check("rst_mid:stays_idle", 32'({axi.M_ARValid, axi.M_AWValid, DMA_done}), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    ARESETn = 1'b0;
    DMAEN = 1'b0; DMASRC = '0; DMADST = '0; DMALEN = '0;
    repeat (3) @(negedge ACLK);
    check_outputs_zero("reset");
    ARESETn = 1'b1;
    @(negedge ACLK);

    run_xfer("len4",     32'h0000_1000, 32'h0000_2000, 32'd4,  0,  -1, -1, 14);
    run_xfer("len40",    32'h0000_3000, 32'h0000_5000, 32'd40, 0,  -1, -1, 0);
    run_xfer("cross4k",  32'h0000_1FF8, 32'h0000_6000, 32'd5,  0,  -1, -1, 0);
    run_xfer("stall20",  32'h0000_7002, 32'h0000_8100, 32'd20, 40, -1, -1, 0);
    run_xfer("berr",     32'h0000_B000, 32'h0000_C000, 32'd20, 0,  0,  -1, 0);
    run_xfer("rerr",     32'h0000_D000, 32'h0000_E000, 32'd6,  20, -1, 3,  0);
    run_xfer("len0",     32'h0000_1000, 32'h0000_2000, 32'd0,  0,  -1, -1, 1);
    reset_in_wdata();
    run_xfer("after_rst", 32'h0000_9000, 32'h0000_A000, 32'd3, 25, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
